scan_boundary_wrapper: RTL and testbench

Parametrised boundary-scan wrapper placed around a combinational/latch core: N_IN input cells register pin inputs into the core, N_OUT output cells register core outputs onto pins, and all cells form one serial scan chain. In functional mode it behaves as plain registered input/output flops. In scan mode an internal controller loads a full vector, waits for the core to settle, captures the core response and unloads it on the next load.

---
 rtl/scan_boundary_wrapper_pkg.sv | 28 ++
 rtl/scan_cell.sv | 40 ++++
 rtl/scan_boundary_wrapper.sv | 141 ++++++++++++++
 tb/tb_scan_boundary_wrapper.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_boundary_wrapper_pkg.sv
// scan_wrap_pkg: shared constants for the boundary-scan wrapper.
//   - Controller state encodings (IDLE, SHIFT, SETTLE, CAPTURE, DONE)
//   - Mode constants (FUNC / SCAN)
//   - Per-cell operation select codes (hold / parallel load / serial shift)
package scan_wrap_pkg;

  typedef logic [2:0] state_t;
  typedef logic [1:0] cell_op_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SHIFT   = 3'd1;
  localparam state_t ST_SETTLE  = 3'd2;
  localparam state_t ST_CAPTURE = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  localparam logic MODE_FUNC = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  localparam cell_op_t CELL_HOLD  = 2'd0;
  localparam cell_op_t CELL_LOAD  = 2'd1;
  localparam cell_op_t CELL_SHIFT = 2'd2;

  // True while the controller owns the chain and a sequence is in progress.
  function automatic logic state_is_busy(input state_t st);
    return (st == ST_SHIFT) || (st == ST_SETTLE) || (st == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/scan_cell.sv
// scan_cell: a single boundary-scan storage flop.
//   clk_i   : clock, rising edge
//   clr_i   : synchronous active-high clear (wins over everything)
//   op_i    : CELL_HOLD / CELL_LOAD / CELL_SHIFT
//   load_i  : parallel data (pin or core side)
//   shift_i : serial data from the previous cell in the chain
//   q_o     : cell contents
module scan_cell
  import scan_wrap_pkg::*;
(
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic [1:0] op_i,
  input  logic       load_i,
  input  logic       shift_i,
  output logic       q_o
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    case (op_i)
      CELL_LOAD:  q_d = load_i;
      CELL_SHIFT: q_d = shift_i;
      default:    q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/scan_boundary_wrapper.sv
// scan_boundary_wrapper: boundary-scan wrapper around a combinational core.
// Chain order: ScanIn -> in[0] .. in[N_IN-1] -> out[0] .. out[N_OUT-1] -> ScanOut.
//   ScanClk   : sole clock, rising edge
//   ScanClr   : synchronous active-high reset
//   ScanMode  : 0 = functional (cells load every edge), 1 = scan
//   ScanStart : request one shift/settle/capture sequence
//   ScanIn    : serial chain input
//   ScanOut   : serial chain output (last output cell)
//   ScanBusy  : high in SHIFT, SETTLE, CAPTURE
//   ScanDone  : one-cycle pulse in DONE
//   PinIn     : chip-side inputs -> input cells
//   CoreIn    : input-cell contents to core
//   CoreOut   : core outputs -> output cells
//   PinOut    : output-cell contents to pins
module scan_boundary_wrapper
  import scan_wrap_pkg::*;
#(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned N_OUT      = 3,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic             ScanClk,
  input  logic             ScanClr,
  input  logic             ScanMode,
  input  logic             ScanStart,
  input  logic             ScanIn,
  output logic             ScanOut,
  output logic             ScanBusy,
  output logic             ScanDone,
  input  logic [N_IN-1:0]  PinIn,
  output logic [N_IN-1:0]  CoreIn,
  input  logic [N_OUT-1:0] CoreOut,
  output logic [N_OUT-1:0] PinOut
);

  localparam int unsigned L    = N_IN + N_OUT;
  localparam int unsigned CntW = $clog2(L + 1);
  localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);

  localparam logic [CntW-1:0] ShiftLast  = CntW'(L - 1);
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYC - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] shift_cnt_q, shift_cnt_d;
  logic [SetW-1:0] settle_cnt_q, settle_cnt_d;
  cell_op_t        in_op, out_op;

  logic [L-1:0] chain;
  logic [L-1:0] par_in;
  logic [L-1:0] ser_in;

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    shift_cnt_d  = shift_cnt_q;
    settle_cnt_d = settle_cnt_q;
    in_op        = CELL_HOLD;
    out_op       = CELL_HOLD;

    if (ScanMode == MODE_FUNC) begin
      // Functional mode also aborts any sequence in flight on this same edge.
      state_d = ST_IDLE;
      in_op   = CELL_LOAD;
      out_op  = CELL_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ScanStart) begin
            state_d     = ST_SHIFT;
            shift_cnt_d = '0;
          end
        end
        ST_SHIFT: begin
          in_op       = CELL_SHIFT;
          out_op      = CELL_SHIFT;
          shift_cnt_d = shift_cnt_q + 1'b1;
          if (shift_cnt_q == ShiftLast) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
          end
        end
        ST_SETTLE: begin
          settle_cnt_d = settle_cnt_q + 1'b1;
          if (settle_cnt_q == SettleLast) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          out_op  = CELL_LOAD;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          // ScanStart is deliberately not looked at here: no queuing.
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge ScanClk) begin
    if (ScanClr) begin
      state_q      <= ST_IDLE;
      shift_cnt_q  <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_cnt_q  <= shift_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Boundary cells and chain wiring
  // ---------------------------------------------------------------------------
  assign par_in = {CoreOut, PinIn};
  assign ser_in = {chain[L-2:0], ScanIn};

  for (genvar i = 0; i < int'(L); i++) begin : g_cell
    localparam bit IsIn = (i < int'(N_IN));
    scan_cell u_cell (
      .clk_i   (ScanClk),
      .clr_i   (ScanClr),
      .op_i    (IsIn ? in_op : out_op),
      .load_i  (par_in[i]),
      .shift_i (ser_in[i]),
      .q_o     (chain[i])
    );
  end

  assign CoreIn   = chain[N_IN-1:0];
  assign PinOut   = chain[L-1:N_IN];
  assign ScanOut  = chain[L-1];
  assign ScanBusy = state_is_busy(state_q);
  assign ScanDone = (state_q == ST_DONE);

endmodule

// File: tb/tb_scan_boundary_wrapper.sv
module tb_scan_boundary_wrapper;

  localparam int unsigned N_IN       = 4;
  localparam int unsigned N_OUT      = 3;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned SEQ_BUSY   = N_IN + N_OUT + SETTLE_CYC + 1;

  logic             ScanClk = 1'b0;
  logic             ScanClr;
  logic             ScanMode;
  logic             ScanStart;
  logic             ScanIn;
  logic             ScanOut;
  logic             ScanBusy;
  logic             ScanDone;
  logic [N_IN-1:0]  PinIn;
  logic [N_IN-1:0]  CoreIn;
  logic [N_OUT-1:0] CoreOut;
  logic [N_OUT-1:0] PinOut;

  scan_boundary_wrapper #(
    .N_IN       (N_IN),
    .N_OUT      (N_OUT),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .ScanClk   (ScanClk),
    .ScanClr   (ScanClr),
    .ScanMode  (ScanMode),
    .ScanStart (ScanStart),
    .ScanIn    (ScanIn),
    .ScanOut   (ScanOut),
    .ScanBusy  (ScanBusy),
    .ScanDone  (ScanDone),
    .PinIn     (PinIn),
    .CoreIn    (CoreIn),
    .CoreOut   (CoreOut),
    .PinOut    (PinOut)
  );

  always #5 ScanClk = ~ScanClk;

  typedef struct packed {
    logic [N_IN-1:0]  pin;
    logic [N_OUT-1:0] core;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[5];
  vec_t exp_q[$];
  logic bit_q[$];

  task automatic tick();
    @(posedge ScanClk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ld_bits;
    vec_t       e;
    logic       seen;
    int         busy_n;
    int         done_n;

    ScanClr   = 1'b1;
    ScanMode  = 1'b0;
    ScanStart = 1'b0;
    ScanIn    = 1'b0;
    PinIn     = 4'hF;
    CoreOut   = 3'h7;

    // Reset: two cycles, inputs busy on the pins, everything must read zero.
    tick();
    tick();
    check("rst_corein", 32'(CoreIn), 32'h0);
    check("rst_pinout", 32'(PinOut), 32'h0);
    check("rst_busy", 32'(ScanBusy), 32'h0);
    check("rst_done", 32'(ScanDone), 32'h0);
    check("rst_scanout", 32'(ScanOut), 32'h0);
    ScanClr = 1'b0;

    // Functional mode: table of pin/core vectors, one-cycle latency each way.
    vecs[0] = '{pin: 4'b1010, core: 3'b101};
    vecs[1] = '{pin: 4'b0101, core: 3'b010};
    vecs[2] = '{pin: 4'b1111, core: 3'b111};
    vecs[3] = '{pin: 4'b0000, core: 3'b000};
    vecs[4] = '{pin: 4'b1001, core: 3'b110};
    for (int i = 0; i < 5; i++) begin
      PinIn   = vecs[i].pin;
      CoreOut = vecs[i].core;
      exp_q.push_back(vecs[i]);
      ScanStart = i[0];  // ignored in functional mode
      tick();
      e = exp_q.pop_front();
      check($sformatf("func_corein_%0d", i), 32'(CoreIn), 32'(e.pin));
      check($sformatf("func_pinout_%0d", i), 32'(PinOut), 32'(e.core));
      check($sformatf("func_busy_%0d", i), 32'(ScanBusy), 32'h0);
    end
    ScanStart = 1'b0;

    // Scan load: bits 1,0,1,1,0,0,1 in order; first bit ends in out[2].
    ld_bits  = 7'b1001101;
    ScanMode = 1'b1;
    ScanStart = 1'b1;
    tick();
    ScanStart = 1'b0;
    busy_n = int'(ScanBusy);
    done_n = 0;
    for (int k = 0; k < 7; k++) begin
      ScanIn = ld_bits[k];
      tick();
      busy_n += int'(ScanBusy);
      done_n += int'(ScanDone);
    end
    check("load_corein", 32'(CoreIn), 32'b1001);
    check("load_pinout", 32'(PinOut), 32'b101);
    CoreOut = 3'b110;
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      tick();
      busy_n += int'(ScanBusy);
      if (ScanDone) begin
        done_n++;
        seen = 1'b1;
      end
    end
    check("load_done_seen", 32'(seen), 32'h1);
    check("load_busy_cycles", 32'(busy_n), 32'(SEQ_BUSY));
    check("load_capture_pinout", 32'(PinOut), 32'b110);
    check("load_corein_held", 32'(CoreIn), 32'b1001);
    tick();
    done_n += int'(ScanDone);
    check("load_done_pulses", 32'(done_n), 32'h1);
    check("load_idle_busy", 32'(ScanBusy), 32'h0);

    // Unload with ScanStart held high through busy and DONE: only one sequence.
    bit_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ScanStart = 1'b1;
    tick();
    busy_n = int'(ScanBusy);
    done_n = 0;
    for (int k = 0; k < 7; k++) begin
      ScanIn = 1'b0;
      check($sformatf("unload_bit_%0d", k), 32'(ScanOut), 32'(bit_q.pop_front()));
      tick();
      busy_n += int'(ScanBusy);
      done_n += int'(ScanDone);
    end
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      tick();
      busy_n += int'(ScanBusy);
      if (ScanDone) begin
        done_n++;
        seen = 1'b1;
      end
    end
    check("unload_done_seen", 32'(seen), 32'h1);
    check("unload_busy_cycles", 32'(busy_n), 32'(SEQ_BUSY));
    tick();  // DONE -> IDLE with ScanStart still high: must be ignored
    ScanStart = 1'b0;
    check("unload_no_restart", 32'(ScanBusy), 32'h0);
    for (int t = 0; t < 3; t++) begin
      tick();
      busy_n += int'(ScanBusy);
      done_n += int'(ScanDone);
    end
    check("unload_single_seq_busy", 32'(busy_n), 32'(SEQ_BUSY));
    check("unload_single_seq_done", 32'(done_n), 32'h1);

    // Abort: drop ScanMode before the third shift edge.
    ScanStart = 1'b1;
    tick();
    ScanStart = 1'b0;
    ScanIn = 1'b1;
    tick();
    tick();
    ScanMode = 1'b0;
    PinIn    = 4'b0110;
    CoreOut  = 3'b011;
    tick();
    check("abort_busy", 32'(ScanBusy), 32'h0);
    check("abort_done", 32'(ScanDone), 32'h0);
    check("abort_corein", 32'(CoreIn), 32'b0110);
    check("abort_pinout", 32'(PinOut), 32'b011);
    done_n = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      done_n += int'(ScanDone);
    end
    check("abort_no_done", 32'(done_n), 32'h0);

    // ScanClr during SETTLE.
    ScanMode  = 1'b1;
    ScanStart = 1'b1;
    tick();
    ScanStart = 1'b0;
    ScanIn = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    check("clr_pre_busy", 32'(ScanBusy), 32'h1);
    check("clr_pre_corein", 32'(CoreIn), 32'hF);
    ScanClr = 1'b1;
    tick();
    ScanClr = 1'b0;
    check("clr_corein", 32'(CoreIn), 32'h0);
    check("clr_pinout", 32'(PinOut), 32'h0);
    check("clr_scanout", 32'(ScanOut), 32'h0);
    check("clr_busy", 32'(ScanBusy), 32'h0);
    busy_n = 0;
    done_n = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      busy_n += int'(ScanBusy);
      done_n += int'(ScanDone);
    end
    check("clr_no_busy", 32'(busy_n), 32'h0);
    check("clr_no_done", 32'(done_n), 32'h0);
    check("clr_corein_held", 32'(CoreIn), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
